// File: rtl/mem_if_pkg.sv
// Purpose: shared types for the RAM initiator: FSM state encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE/SETUP/ACCESS/DONE, 2 bits), lat_cnt_width() for the read-latency counter.
package mem_if_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter must be able to hold READ_LATENCY-1; $clog2(READ_LATENCY+1) keeps at least one bit.
    function automatic int lat_cnt_width(input int read_latency);
        return (read_latency < 1) ? 1 : $clog2(read_latency + 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Purpose: bundles the CPU request side and the RAM strobe side of the memory access controller.
// Latency: n/a (wiring only).
// Backpressure: cpu_busy tells the requester that cpu_req is being ignored.
// Modports: master = the controller (drives strobes, busy/done/rdata); slave = CPU + RAM environment.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [31:0]              cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wdata;
    logic                     cpu_busy;
    logic                     cpu_done;
    logic                     cpu_fault;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_data_in;
    logic [DATA_WIDTH-1:0]    mem_data_out;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
        output cpu_busy, cpu_done, cpu_fault, cpu_rdata,
               mem_read, mem_write, mem_address, mem_data_in
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_out,
        input  cpu_busy, cpu_done, cpu_fault, cpu_rdata,
               mem_read, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/mem_latency_counter.sv
// Purpose: loadable down-counter timing how long mem_read is held, with a zero flag.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; saturates at 0 if decremented further.
// Ports: Clock, clear_n (async active-low), load/load_value, dec, zero.
module mem_latency_counter #(
    parameter int WIDTH = 1
) (
    input  logic             Clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: single-outstanding load/store initiator for the word-addressed RAM (MAR/MDR + sequencer).
// Latency: request edge to sampled cpu_done = 3 cycles for a store, 2+READ_LATENCY for a load.
// Backpressure: cpu_busy is high outside IDLE; cpu_req arriving while busy is dropped, not queued.
// Ports: Clock, clear_n (async active-low), bus (mem_access_ctrl_if.master: cpu_* request/response,
//        mem_read/mem_write/mem_address/mem_data_in to the RAM, mem_data_out from it).
// Option: define MEM_BOUNDS_CHECK_EN to fault addresses >= MEM_SIZE instead of wrapping them.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int MEM_SIZE      = 512,
    parameter int READ_LATENCY  = 1
) (
    input  logic              Clock,
    input  logic              clear_n,
    mem_access_ctrl_if.master bus
);
    localparam int               CNT_W    = lat_cnt_width(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t                   state;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0]    mdr;
    logic                     busy_q;
    logic                     done_q;
    logic                     read_q;
    logic                     write_q;
    logic                     cnt_load;
    logic                     cnt_dec;
    logic                     cnt_zero;

`ifdef MEM_BOUNDS_CHECK_EN
    logic fault_pend;
    logic fault_q;
    logic in_range;

    // Compare the full 32-bit address so that high bits cannot alias into range.
    assign in_range = (bus.cpu_addr < 32'(MEM_SIZE));
`else
    // Upper address bits are intentionally dropped: out-of-range addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.cpu_addr[31:ADDRESS_WIDTH];
`endif

    // Counter is preloaded during SETUP so the first ACCESS cycle already sees READ_LATENCY-1.
    assign cnt_load = (state == SETUP);
    assign cnt_dec  = (state == ACCESS) && !we_q;

    mem_latency_counter #(
        .WIDTH (CNT_W)
    ) u_lat_cnt (
        .Clock      (Clock),
        .clear_n    (clear_n),
        .load       (cnt_load),
        .load_value (CNT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            mar     <= '0;
            mdr     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            fault_pend <= 1'b0;
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        state  <= SETUP;
                        busy_q <= 1'b1;
                        we_q   <= bus.cpu_we;
                        mar    <= bus.cpu_addr[ADDRESS_WIDTH-1:0];
`ifdef MEM_BOUNDS_CHECK_EN
                        fault_pend <= !in_range;
                        // A faulting store must leave MDR (and so cpu_rdata) untouched.
                        if (bus.cpu_we && in_range) begin
                            mdr <= bus.cpu_wdata;
                        end
`else
                        if (bus.cpu_we) begin
                            mdr <= bus.cpu_wdata;
                        end
`endif
                    end
                end

                SETUP: begin
`ifdef MEM_BOUNDS_CHECK_EN
                    if (fault_pend) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else
`endif
                    begin
                        state <= ACCESS;
                        if (we_q) begin
                            write_q <= 1'b1;
                        end else begin
                            read_q <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (we_q) begin
                        write_q <= 1'b0;
                        state   <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_zero) begin
                        read_q <= 1'b0;
                        mdr    <= bus.mem_data_out;
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
                    fault_q <= 1'b0;
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_busy    = busy_q;
    assign bus.cpu_done    = done_q;
    assign bus.cpu_rdata   = mdr;
    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;
    assign bus.mem_address = mar;
    assign bus.mem_data_in = mdr;
`ifdef MEM_BOUNDS_CHECK_EN
    assign bus.cpu_fault   = fault_q;
`else
    assign bus.cpu_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: scoreboard bench for mem_access_ctrl; instance 0 uses READ_LATENCY=1, instance 1 uses 3.
// Latency: expected cpu_done edge is derived from the request edge for every access.
// Backpressure: requests are issued only when idle, or held high to show busy requests are dropped.
module tb_mem_access_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    wire  [1:0]  busy;
    wire  [1:0]  done;
    wire  [1:0]  fault;
    wire  [1:0]  mrd;
    wire  [1:0]  mwr;
    wire  [31:0] rdata [2];
    wire  [31:0] mdin  [2];
    wire  [8:0]  maddr [2];

    logic [31:0] ram [512];
    logic [31:0] mdr_m [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int dut; int exp_edge; logic flt; logic [31:0] rdata; } done_t;
    typedef struct { int dut; logic [8:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int dut; logic [8:0] addr; int len; } rd_t;

    done_t done_q [$];
    wr_t   wr_q   [$];
    rd_t   rd_q   [$];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

        assign bus.cpu_req      = req[g];
        assign bus.cpu_we       = we[g];
        assign bus.cpu_addr     = addr[g];
        assign bus.cpu_wdata    = wdata[g];
        assign bus.mem_data_out = ram[bus.mem_address];
        assign busy[g]          = bus.cpu_busy;
        assign done[g]          = bus.cpu_done;
        assign fault[g]         = bus.cpu_fault;
        assign mrd[g]           = bus.mem_read;
        assign mwr[g]           = bus.mem_write;
        assign rdata[g]         = bus.cpu_rdata;
        assign mdin[g]          = bus.mem_data_in;
        assign maddr[g]         = bus.mem_address;

        mem_access_ctrl #(
            .DATA_WIDTH    (DW),
            .ADDRESS_WIDTH (AW),
            .MEM_SIZE      (512),
            .READ_LATENCY  ((g == 0) ? 1 : 3)
        ) dut (
            .Clock   (clk),
            .clear_n (rst_n[g]),
            .bus     (bus)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model: word i initialised to 0xA5000000|i, written on the edge that ends a write cycle.
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'hA500_0000 | 32'(i);
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mwr[d] && rst_n[d]) ram[maddr[d]] = mdin[d];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: samples on the falling edge, pops expectations when the DUT presents an event.
    initial begin
        int    run [2];
        rd_t   cur [2];
        done_t de;
        wr_t   wr;
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n[d] !== 1'b1) begin
                    run[d] = 0;
                end else begin
                    check("strobe_excl", 64'(mrd[d] & mwr[d]), 64'd0);
                    if (done[d]) begin
                        if (done_q.size() != 0 && done_q[0].dut == d) begin
                            de = done_q.pop_front();
                            check("done_edge", 64'(cyc + 1), 64'(de.exp_edge));
                            check("done_fault", 64'(fault[d]), 64'(de.flt));
                            check("done_rdata", 64'(rdata[d]), 64'(de.rdata));
                            check("done_busy", 64'(busy[d]), 64'd1);
                        end else begin
                            check("unexpected_done", 64'(done[d]), 64'd0);
                        end
                    end
                    if (mwr[d]) begin
                        check("write_busy", 64'(busy[d]), 64'd1);
                        if (wr_q.size() != 0 && wr_q[0].dut == d) begin
                            wr = wr_q.pop_front();
                            check("write_addr", 64'(maddr[d]), 64'(wr.addr));
                            check("write_data", 64'(mdin[d]), 64'(wr.data));
                        end else begin
                            check("unexpected_write", 64'(mwr[d]), 64'd0);
                        end
                    end
                    if (mrd[d]) begin
                        if (run[d] == 0) begin
                            check("read_busy", 64'(busy[d]), 64'd1);
                            if (rd_q.size() != 0 && rd_q[0].dut == d) begin
                                cur[d] = rd_q.pop_front();
                                check("read_addr", 64'(maddr[d]), 64'(cur[d].addr));
                            end else begin
                                cur[d].len = 0;
                                check("unexpected_read", 64'(mrd[d]), 64'd0);
                            end
                        end
                        run[d]++;
                    end else if (run[d] != 0) begin
                        check("read_len", 64'(run[d]), 64'(cur[d].len));
                        run[d] = 0;
                    end
                end
            end
        end
    end

    // Issue one request (held for 'hold' cycles); data = store data, or the hand-computed load result.
    task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                         input int hold);
        int    rl;
        int    lat;
        int    e0;
        bit    flt;
        done_t de;
        wr_t   wr;
        rd_t   rd;
        rl = (d == 0) ? 1 : 3;
`ifdef MEM_BOUNDS_CHECK_EN
        flt = (a >= 32'd512);
`else
        flt = 1'b0;
`endif
        lat = flt ? 2 : (w ? 3 : 2 + rl);
        e0  = cyc + 1;
        // A held request is re-accepted one cycle after DONE, i.e. every lat+1 edges.
        for (int k = 0; k * (lat + 1) <= hold - 1; k++) begin
            if (!flt) begin
                if (w) begin
                    wr.dut = d; wr.addr = a[8:0]; wr.data = data;
                    wr_q.push_back(wr);
                end else begin
                    rd.dut = d; rd.addr = a[8:0]; rd.len = rl;
                    rd_q.push_back(rd);
                end
                mdr_m[d] = data;
            end
            de.dut = d; de.exp_edge = e0 + k * (lat + 1) + lat; de.flt = flt; de.rdata = mdr_m[d];
            done_q.push_back(de);
        end
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = w ? data : 32'h5555_5555;
        repeat (hold) @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (busy[d] == 1'b0 && done_q.size() == 0) ok = 1'b1;
        end
        check("wait_idle", 64'(ok), 64'd1);
    endtask

    initial begin
        bit seen;
        rst_n    = 2'b00;
        req      = 2'b00;
        we       = 2'b00;
        addr[0]  = '0; addr[1]  = '0;
        wdata[0] = '0; wdata[1] = '0;
        mdr_m[0] = '0; mdr_m[1] = '0;

        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ctl", 64'({busy[d], done[d], fault[d], mrd[d], mwr[d]}), 64'd0);
            check("rst_rdata", 64'(rdata[d]), 64'd0);
            check("rst_addr", 64'(maddr[d]), 64'd0);
            check("rst_wdata", 64'(mdin[d]), 64'd0);
        end
        @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);

        // Store then load back, plus an untouched word.
        issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1);  wait_idle(0);
        issue(0, 1'b0, 32'd5, 32'hDEAD_BEEF, 1);  wait_idle(0);
        issue(0, 1'b0, 32'd7, 32'hA500_0007, 1);  wait_idle(0);

        // Longer read latency at the top address.
        issue(1, 1'b0, 32'h1FF, 32'hA500_01FF, 1); wait_idle(1);

        // Held request: 4 cycles gives one access, 5 cycles gives a second one right after IDLE.
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 4); wait_idle(0);
        issue(0, 1'b1, 32'h21, 32'hCAFE_F00D, 5); wait_idle(0);
        issue(0, 1'b0, 32'h21, 32'hCAFE_F00D, 1); wait_idle(0);

        // Out-of-range addresses: fault, or wrap to the low 9 bits.
        issue(0, 1'b1, 32'd600, 32'h0BAD_0258, 1); wait_idle(0);
`ifdef MEM_BOUNDS_CHECK_EN
        issue(0, 1'b0, 32'd88, 32'hA500_0058, 1);  wait_idle(0);
        issue(0, 1'b0, 32'd1000, 32'h0, 1);        wait_idle(0);
`else
        issue(0, 1'b0, 32'd88, 32'h0BAD_0258, 1);  wait_idle(0);
        issue(0, 1'b0, 32'd1000, 32'hA500_01E8, 1); wait_idle(0);
`endif

        // Reset in the middle of a load ACCESS.
        issue(1, 1'b0, 32'h10, 32'hA500_0010, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mrd[1];
        end
        check("abort_read_seen", 64'(seen), 64'd1);
        rst_n[1] = 1'b0;
        #1;
        check("abort_mem_read", 64'(mrd[1]), 64'd0);
        check("abort_busy", 64'(busy[1]), 64'd0);
        check("abort_rdata", 64'(rdata[1]), 64'd0);
        for (int i = done_q.size() - 1; i >= 0; i--) if (done_q[i].dut == 1) done_q.delete(i);
        for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].dut == 1) rd_q.delete(i);
        mdr_m[1] = '0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 64'(done[1]), 64'd0);
        rst_n[1] = 1'b1;
        repeat (5) @(negedge clk);
        issue(1, 1'b0, 32'd3, 32'hA500_0003, 1); wait_idle(1);

        repeat (3) @(negedge clk);
        check("queues_empty", 64'(done_q.size() + wr_q.size() + rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
